// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported 16-bit synchronous memory between fetch and data requesters.
// Optional macro FAIR_ARB_EN adds a fairness window that forces a fetch grant after FAIR_WIN data grants.
module mem_arbiter #(
  parameter int unsigned AW = 16
`ifdef FAIR_ARB_EN
  ,
  parameter int unsigned FAIR_WIN = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic          f_wide,
  input  logic [AW-1:0] f_addr,
  input  logic          f_kill,
  output logic          f_done,
  output logic [31:0]   f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_wide,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned HW = 16;
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Latched access context
  logic          owner;
  logic          acc_we;
  logic          acc_wide;
  logic [AW-1:0] base;
  logic [DW-1:0] wdata;
  logic [HW-1:0] lo;
  logic          kill;
  logic [DW-1:0] f_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          grant_d;
  logic          grant_f;
  logic          grant;
  logic          fair_force;
  logic          kill_now;
  logic [DW-1:0] rdata_asm;

  logic          own_nxt;
  logic          we_nxt;
  logic          wide_nxt;
  logic [AW-1:0] base_nxt;
  logic [DW-1:0] wdata_nxt;

  logic          mem_en_nxt;
  logic          mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [HW-1:0] mem_wdata_nxt;
  logic          f_done_nxt;
  logic          d_done_nxt;

`ifdef FAIR_ARB_EN
  localparam int unsigned CW = $clog2(FAIR_WIN + 1);
  logic [CW-1:0] fair_cnt;

  assign fair_force = f_req && (fair_cnt >= CW'(FAIR_WIN));

  // Counts data grants that made a waiting fetch lose; any fetch grant restarts the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fair_cnt <= '0;
    end else if (grant_f) begin
      fair_cnt <= '0;
    end else if (grant_d && f_req && (fair_cnt < CW'(FAIR_WIN))) begin
      fair_cnt <= fair_cnt + CW'(1);
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  assign grant_d  = (state == IDLE) && d_req && !fair_force;
  assign grant_f  = (state == IDLE) && f_req && !grant_d;
  assign grant    = grant_d || grant_f;
  assign kill_now = f_kill && (state != IDLE) && (owner == OWN_F);

  // Access context for the cycle after this one: freshly granted request or the held one
  always_comb begin
    own_nxt   = owner;
    we_nxt    = acc_we;
    wide_nxt  = acc_wide;
    base_nxt  = base;
    wdata_nxt = wdata;
    if (grant_d) begin
      own_nxt   = OWN_D;
      we_nxt    = d_we;
      wide_nxt  = d_wide;
      base_nxt  = d_addr;
      wdata_nxt = d_wdata;
    end else if (grant_f) begin
      own_nxt   = OWN_F;
      we_nxt    = 1'b0;
      wide_nxt  = f_wide;
      base_nxt  = f_addr;
      wdata_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACC0;
      ACC0:    state_nxt = acc_wide ? ACC1 : DONE;
      ACC1:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register inputs are decoded from the next state so mem_* never see req combinationally
  always_comb begin
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    f_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    case (state_nxt)
      ACC0: begin
        mem_en_nxt    = 1'b1;
        mem_we_nxt    = we_nxt;
        mem_addr_nxt  = base_nxt;
        mem_wdata_nxt = we_nxt ? wdata_nxt[HW-1:0] : '0;
      end
      ACC1: begin
        mem_en_nxt    = 1'b1;
        mem_we_nxt    = acc_we;
        mem_addr_nxt  = base + AW'(1);
        mem_wdata_nxt = acc_we ? wdata[DW-1:HW] : '0;
      end
      DONE: begin
        f_done_nxt = (owner == OWN_F) && !kill && !kill_now;
        d_done_nxt = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  assign rdata_asm = acc_wide ? {mem_rdata, lo} : {HW'(0), mem_rdata};

  // The last beat's read data lands in DONE, so the done cycle forwards it past the holding register
  assign f_rdata = f_done ? rdata_asm : f_rdata_q;
  assign d_rdata = (d_done && !acc_we) ? rdata_asm : d_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_F;
      acc_we    <= 1'b0;
      acc_wide  <= 1'b0;
      base      <= '0;
      wdata     <= '0;
      lo        <= '0;
      kill      <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      owner     <= own_nxt;
      acc_we    <= we_nxt;
      acc_wide  <= wide_nxt;
      base      <= base_nxt;
      wdata     <= wdata_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      f_done    <= f_done_nxt;
      d_done    <= d_done_nxt;
      if (state == ACC1) begin
        lo <= mem_rdata;
      end
      if (state_nxt == IDLE) begin
        kill <= 1'b0;
      end else if (kill_now) begin
        kill <= 1'b1;
      end
      if (f_done) begin
        f_rdata_q <= rdata_asm;
      end
      if (d_done && !acc_we) begin
        d_rdata_q <= rdata_asm;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized accesses against a word-atomic memory reference model.
// Completions are scored in done order, since the single port serialises every access.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_req = 1'b0, f_wide = 1'b0, f_kill = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_wide = 1'b0;
  logic [15:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_wide(f_wide), .f_addr(f_addr), .f_kill(f_kill),
    .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory seen by the DUT, and the reference image updated at each completion
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    bit          we;
    bit          wide;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          exp_cyc;
  } acc_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } beat_t;

  acc_t        fq[$];
  acc_t        dq[$];
  bit          gq[$];
  beat_t       beat_exp[int];
  bit          beat_chk = 1'b0;
  bit          grant_chk = 1'b0;
  logic [31:0] f_hold = '0;
  logic [31:0] d_hold = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  function automatic logic [31:0] ref_read(input logic [15:0] a, input bit wide);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return wide ? {ref_mem[a1], ref_mem[a]} : {16'h0000, ref_mem[a]};
  endfunction

  task automatic ref_write(input logic [15:0] a, input bit wide, input logic [31:0] wd);
    logic [15:0] a1;
    a1 = a + 16'd1;
    ref_mem[a] = wd[15:0];
    if (wide) ref_mem[a1] = wd[31:16];
  endtask

  // Monitor: pops the expected response whenever the DUT presents a done or a memory beat
  initial begin
    acc_t        r;
    beat_t       b;
    logic [31:0] e;
    bit          g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_ctrl", 64'({f_done, d_done, mem_en, mem_we, mem_addr, mem_wdata}), 64'd0);
        chk("reset_rdata", 64'({f_rdata, d_rdata}), 64'd0);
        f_hold = '0;
        d_hold = '0;
      end else begin
        if (mem_en && beat_chk) begin
          if (beat_exp.exists(cyc)) begin
            b = beat_exp[cyc];
            beat_exp.delete(cyc);
            chk("beat_we", 64'(mem_we), 64'(b.we));
            chk("beat_addr", 64'(mem_addr), 64'(b.addr));
            if (b.we) chk("beat_wdata", 64'(mem_wdata), 64'(b.wdata));
          end else begin
            fail_now("beat_unexpected", $sformatf("mem_en=1 addr 0x%0h, required mem_en=0", mem_addr));
          end
        end
        if (f_done) begin
          if (fq.size() == 0) begin
            fail_now("f_done_unexpected", "f_done=1, required 0 (no fetch owed)");
          end else begin
            r = fq.pop_front();
            e = ref_read(r.addr, r.wide);
            chk("f_rdata", 64'(f_rdata), 64'(e));
            f_hold = e;
            if (r.exp_cyc >= 0) chk("f_done_cycle", 64'(cyc), 64'(r.exp_cyc));
            if (grant_chk) begin
              if (gq.size() == 0) fail_now("grant_order", "fetch completed, required no more grants");
              else begin
                g = gq.pop_front();
                chk("grant_order", 64'(1'b0), 64'(g));
              end
            end
          end
        end else begin
          chk("f_rdata_hold", 64'(f_rdata), 64'(f_hold));
        end
        if (d_done) begin
          if (dq.size() == 0) begin
            fail_now("d_done_unexpected", "d_done=1, required 0 (no data access owed)");
          end else begin
            r = dq.pop_front();
            if (r.we) begin
              chk("d_rdata_hold_on_write", 64'(d_rdata), 64'(d_hold));
              ref_write(r.addr, r.wide, r.wdata);
            end else begin
              e = ref_read(r.addr, r.wide);
              chk("d_rdata", 64'(d_rdata), 64'(e));
              d_hold = e;
            end
            if (r.exp_cyc >= 0) chk("d_done_cycle", 64'(cyc), 64'(r.exp_cyc));
            if (grant_chk) begin
              if (gq.size() == 0) fail_now("grant_order", "data completed, required no more grants");
              else begin
                g = gq.pop_front();
                chk("grant_order", 64'(1'b1), 64'(g));
              end
            end
          end
        end else begin
          chk("d_rdata_hold", 64'(d_rdata), 64'(d_hold));
        end
      end
    end
  end

  task automatic push_beats(input int done_cyc, input bit we, input bit wide,
                            input logic [15:0] addr, input logic [31:0] wd);
    beat_t b;
    b.we = we;
    if (wide) begin
      b.addr = addr;         b.wdata = wd[15:0];  beat_exp[done_cyc-2] = b;
      b.addr = addr + 16'd1; b.wdata = wd[31:16]; beat_exp[done_cyc-1] = b;
    end else begin
      b.addr = addr;         b.wdata = wd[15:0];  beat_exp[done_cyc-1] = b;
    end
  endtask

  task automatic wait_done(input bit is_data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = is_data ? d_done : f_done;
    end
    if (!seen) fail_now(is_data ? "d_timeout" : "f_timeout", "done=0 for 100 cycles, required a done pulse");
  endtask

  // Called just after a rising edge; lat < 0 means completion time is not checked
  task automatic data_access(input bit we, input bit wide, input logic [15:0] addr,
                             input logic [31:0] wd, input int lat);
    acc_t r;
    r.we = we; r.wide = wide; r.addr = addr; r.wdata = wd;
    r.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    if (lat >= 0) push_beats(r.exp_cyc, we, wide, addr, wd);
    dq.push_back(r);
    d_req = 1'b1; d_we = we; d_wide = wide; d_addr = addr; d_wdata = wd;
    wait_done(1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_access(input bit wide, input logic [15:0] addr, input int lat);
    acc_t r;
    r.we = 1'b0; r.wide = wide; r.addr = addr; r.wdata = '0;
    r.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    if (lat >= 0) push_beats(r.exp_cyc, 1'b0, wide, addr, 32'h0);
    fq.push_back(r);
    f_req = 1'b1; f_wide = wide; f_addr = addr;
    wait_done(1'b0);
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] b;
    b = ($urandom_range(0, 1) == 1) ? 16'h0100 : 16'hFFF8;
    return b + 16'($urandom_range(0, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    bit exp_seq[10];
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i * 7 + 3) ^ 16'hA5A5;
      ref_mem[i] = 16'(i * 7 + 3) ^ 16'hA5A5;
    end
    mem[16'h0040]     = 16'hBEEF;
    ref_mem[16'h0040] = 16'hBEEF;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    beat_chk = 1'b1;

    fetch_access(1'b0, 16'h0040, 2);
    data_access(1'b1, 1'b1, 16'hFFFF, 32'h1234_5678, 3);
    data_access(1'b0, 1'b1, 16'hFFFF, 32'h0, 3);
    fork
      data_access(1'b0, 1'b0, 16'h0100, 32'h0, 2);
      fetch_access(1'b0, 16'h0101, 5);
    join

    // Wide fetch killed during its second beat: both beats issue, no completion
    c0 = cyc;
    push_beats(c0 + 3, 1'b0, 1'b1, 16'h0104, 32'h0);
    f_req = 1'b1; f_wide = 1'b1; f_addr = 16'h0104;
    @(posedge clk); #1;
    @(posedge clk); #1; f_kill = 1'b1;
    @(posedge clk); #1; f_kill = 1'b0;
    @(posedge clk); #1; f_req = 1'b0;
    fetch_access(1'b0, 16'h0105, 2);
    chk("beats_outstanding", 64'(beat_exp.num()), 64'd0);

    // Reset lands during the second beat of a wide write
    c0 = cyc;
    push_beats(c0 + 2, 1'b1, 1'b0, 16'h0200, 32'hCAFE_F00D);
    d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1; d_addr = 16'h0200; d_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    data_access(1'b0, 1'b0, 16'h0010, 32'h0, 2);
    chk("beats_outstanding_rst", 64'(beat_exp.num()), 64'd0);
    beat_chk = 1'b0;

    // Both requesters continuously busy: grant order shows the arbitration policy
`ifdef FAIR_ARB_EN
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 10; i++) gq.push_back(exp_seq[i]);
    grant_chk = 1'b1;
    fork
      for (int i = 0; i < 8; i++) data_access(1'b0, 1'b0, 16'h0100 + 16'(i), 32'h0, -1);
      for (int i = 0; i < 2; i++) fetch_access(1'b0, 16'h0108 + 16'(i), -1);
    join
    chk("grants_outstanding", 64'(gq.size()), 64'd0);
    grant_chk = 1'b0;

    fork
      begin
        bit we, wide;
        for (int i = 0; i < 40; i++) begin
          we   = 1'($urandom_range(0, 1));
          wide = 1'($urandom_range(0, 1));
          data_access(we, wide, rand_addr(), $urandom, -1);
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
      end
      begin
        bit wide;
        for (int i = 0; i < 40; i++) begin
          wide = 1'($urandom_range(0, 1));
          fetch_access(wide, rand_addr(), -1);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join
    repeat (5) @(posedge clk);
    chk("fq_drained", 64'(fq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported 16-bit synchronous memory between the instruction-fetch requester (f_*) and the memory-stage data requester (d_*).
- Each access is narrow (one 16-bit beat) or wide (two beats, 32-bit: instruction fetch, 32-bit PC push/pop).
- Sequences the beats, assembles or splits the 32-bit words, and returns a one-cycle done pulse per access.
- Sits between fetch_unit/mem_unit and the unified memory model.

Parameters:
- AW, 16, memory word-address width.
- FAIR_WIN, 4, consecutive data grants allowed before fetch is forced (FAIR_ARB_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch request; held until f_done.
- f_wide  in  1  1 = two-beat access.
- f_addr  in  AW  fetch word address; held stable while f_req.
- f_kill  in  1  discard in-flight fetch result (jump/flush).
- f_done  out  1  one-cycle pulse; f_rdata valid.
- f_rdata  out  32  fetched data.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = write.
- d_wide  in  1  1 = two-beat access.
- d_addr  in  AW  data word address; held stable while d_req.
- d_wdata  in  32  write data; held stable while d_req.
- d_done  out  1  one-cycle pulse.
- d_rdata  out  32  read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=fetch, fair count=0.
  - All outputs 0; f_rdata and d_rdata clear to 0.
- States: IDLE, ACC0, ACC1, DONE. All mem_* outputs are driven from registered state/owner/address; no combinational path from req to mem_*.
- IDLE:
  - Samples requests. If any is high, latches owner, we, wide and base address, then goes to ACC0.
  - Fixed priority: data wins over fetch.
  - No request: stays in IDLE; mem_en=0.
- ACC0:
  - mem_en=1, mem_addr=base, mem_we=owner_we, mem_wdata=wdata[15:0].
  - Next state: ACC1 if wide, else DONE.
- ACC1:
  - mem_en=1, mem_addr=base+1 (wraps modulo 2^AW), mem_wdata=wdata[31:16].
  - Captures mem_rdata into the low half of the result.
  - Next state: DONE.
- DONE:
  - Captures mem_rdata into the high half (wide) or low half (narrow; high half=0).
  - Pulses the owner's done for this cycle only; rdata is valid in this cycle and held until the next capture.
  - Next state: IDLE.
- Writes: rdata capture is skipped and the previous value is held.
- Latency from req sampled in IDLE to done: narrow = 2 cycles (ACC0, DONE); wide = 3 cycles.
- A new access can start 1 cycle after done (IDLE cycle). Back-to-back narrow throughput is one access per 3 cycles.
- Requester protocol: req drops in the cycle after done unless a new access is intended. req seen high in IDLE is always a new access.
- f_kill:
  - If asserted in any cycle while owner=fetch and state≠IDLE, a sticky kill flag is set.
  - The beats still complete (memory is never left mid-access).
  - In DONE, f_done is suppressed and f_rdata is not updated. The flag clears on entry to IDLE.
  - f_kill while fetch does not own the port has no effect.
- Simultaneous f_req and d_req in IDLE: data is granted, and fetch waits until the next IDLE.
- Requests arriving mid-access are ignored until IDLE.
- mem_we is only ever 1 for owner=data with d_we=1.

Optional Feature:
- FAIR_ARB_EN:
  - When defined, a counter increments on each data grant taken while f_req is also high, and resets on any fetch grant.
  - When the count reaches FAIR_WIN, the next IDLE with f_req=1 grants fetch regardless of d_req, and the count resets to 0.
- Without FAIR_ARB_EN: strict data-over-fetch priority, and the counter is not instantiated.

Test Plan:
- Reset mid-ACC1 of a wide data write → next cycle: all outputs 0, state IDLE, no further mem_en; after reset release, a d_req narrow read of addr 0x0010 completes normally.
- f_req narrow, f_addr=0x0040, mem[0x40]=0xBEEF → mem_en in cycle 1 at 0x0040; f_done in cycle 2; f_rdata=0x0000BEEF.
- d_req wide write, d_addr=0xFFFF, d_wdata=0x12345678 → beat0 writes 0x5678 at 0xFFFF, beat1 writes 0x1234 at 0x0000 (wrap); d_done in cycle 3.
- f_req and d_req both high in the same cycle (both narrow reads) → data is served first (d_done cycle 2); fetch mem_en in cycle 4, f_done in cycle 5.
- Wide fetch with f_kill pulsed during ACC1 → two mem_en beats still issue; no f_done; f_rdata unchanged; next fetch completes normally.
- FAIR_ARB_EN, FAIR_WIN=4, d_req and f_req continuously high → grant sequence D,D,D,D,F repeating; without the macro, fetch is never granted.
